// File: rtl/volume_meter.sv
// rtl/volume_meter.sv - windowed peak microphone volume meter, level 0..9 (optional decay: VOLUME_METER_DECAY_EN)
module volume_meter #(
  parameter int WINDOW_SAMPLES = 4000,
  parameter int MID            = 2048,
  parameter int STEP           = 205
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_valid,
  input  logic [11:0] mic_in,
  output logic [3:0]  volume_level,
  output logic        level_valid
);

  localparam logic [11:0] MID_C    = 12'(MID);
  localparam logic [15:0] LAST_IDX = 16'(WINDOW_SAMPLES - 1);

  logic [15:0] cnt_q, cnt_d;
  logic [11:0] peak_q, peak_d;
  logic [3:0]  vol_q, vol_d;
  logic        lv_q, lv_d;

  logic [11:0] amp;
  logic [11:0] window_peak;
  logic [3:0]  window_level;
  logic        terminal;

  // Distance of the sample from the silence code; fits 12 bits since it never exceeds 2048.
  always_comb begin
    if (mic_in >= MID_C) amp = mic_in - MID_C;
    else                 amp = MID_C - mic_in;
  end

  // Window close detection and the peak including the closing sample.
  always_comb begin
    terminal    = sample_valid && (cnt_q == LAST_IDX);
    window_peak = (amp > peak_q) ? amp : peak_q;
  end

  // Level quantisation by threshold comparators against multiples of STEP (no divider).
  always_comb begin
    window_level = 4'd0;
    for (int k = 1; k <= 9; k++) begin
      if ({1'b0, window_peak} >= 13'(k * STEP)) window_level = 4'(k);
    end
  end

  // Next-state for counter, running peak, displayed level and update strobe.
  always_comb begin
    cnt_d  = cnt_q;
    peak_d = peak_q;
    vol_d  = vol_q;
    lv_d   = 1'b0;
    if (sample_valid) begin
      if (terminal) begin
        cnt_d  = 16'd0;
        peak_d = 12'd0;
        lv_d   = 1'b1;
`ifdef VOLUME_METER_DECAY_EN
        if (window_level >= vol_q) vol_d = window_level;
        else                       vol_d = vol_q - 4'd1;
`else
        vol_d = window_level;
`endif
      end else begin
        cnt_d  = cnt_q + 16'd1;
        peak_d = window_peak;
      end
    end
  end

  // State registers; reset wins over any sample in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= 16'd0;
      peak_q <= 12'd0;
      vol_q  <= 4'd0;
      lv_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      peak_q <= peak_d;
      vol_q  <= vol_d;
      lv_q   <= lv_d;
    end
  end

  assign volume_level = vol_q;
  assign level_valid  = lv_q;

endmodule

// File: tb/tb_volume_meter.sv
// tb/tb_volume_meter.sv - scoreboard bench for volume_meter with WINDOW_SAMPLES=8
module tb_volume_meter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_valid = 1'b0;
  logic [11:0] mic_in = 12'd0;
  logic [3:0]  volume_level;
  logic        level_valid;

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];
  int expv;

  volume_meter #(.WINDOW_SAMPLES(8), .MID(2048), .STEP(205)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .mic_in       (mic_in),
    .volume_level (volume_level),
    .level_valid  (level_valid)
  );

  always #5 clk = ~clk;

  // Monitor: every update pulse must match the oldest expected level; reset must hold outputs at zero.
  always @(negedge clk) begin
    if (reset) begin
      vectors++;
      if (volume_level !== 4'd0 || level_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_state: volume_level=%0d level_valid=%0b, required 0/0", volume_level, level_valid);
      end
    end else if (level_valid === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse: level_valid=1 volume_level=%0d, required no pulse", volume_level);
      end else begin
        expv = exp_q.pop_front();
        if (volume_level !== 4'(expv)) begin
          miscompares++;
          $display("FAIL window_level: volume_level=%0d, required %0d", volume_level, expv);
        end
      end
    end
  end

  task automatic drive(input logic rst, input logic vld, input int v);
    @(posedge clk);
    #1;
    reset        = rst;
    sample_valid = vld;
    mic_in       = 12'(v);
  endtask

  // One full 8-sample window; 'special' replaces silence at position spos, 'gap' invalid cycles (mic=0) precede each sample.
  task automatic run_window(input int special, input int spos, input int gap, input int exp_plain, input int exp_decay);
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < gap; g++) drive(1'b0, 1'b0, 0);
      drive(1'b0, 1'b1, (i == spos) ? special : 2048);
      if (i == 7) begin
`ifdef VOLUME_METER_DECAY_EN
        exp_q.push_back(exp_decay);
`else
        exp_q.push_back(exp_plain);
`endif
      end
    end
    drive(1'b0, 1'b0, 0);
    drive(1'b0, 1'b0, 0);
  endtask

  initial begin
    drive(1'b1, 1'b1, 0);
    drive(1'b1, 1'b1, 0);
    drive(1'b0, 1'b0, 0);

    run_window(2048, 0, 0, 0, 0);   // silence
    run_window(2458, 0, 0, 2, 2);   // a=410
    run_window(2252, 4, 0, 0, 1);   // a=204, just below one step
    run_window(2253, 4, 0, 1, 1);   // a=205, exactly one step
    run_window(0,    7, 0, 9, 9);   // a=2048 on the terminal sample
    run_window(2048, 0, 0, 0, 8);
    run_window(2048, 0, 0, 0, 7);
    run_window(2048, 0, 0, 0, 6);

    // Reset after 5 loud samples discards the partial window.
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 0);
    drive(1'b1, 1'b1, 0);
    drive(1'b1, 1'b0, 0);
    run_window(2048, 0, 0, 0, 0);

    // Reset coincident with the terminal sample suppresses the pulse.
    for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, 0);
    drive(1'b1, 1'b1, 0);
    drive(1'b0, 1'b0, 0);
    run_window(2048, 0, 0, 0, 0);

    // Sparse samples: loud values on invalid cycles must be ignored.
    run_window(2253, 3, 2, 1, 1);

    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(posedge clk);
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL pulse_timeout: %0d pulses outstanding, required 0", exp_q.size());
    end
    @(negedge clk);
    vectors++;
    if (volume_level !== 4'd1) begin
      miscompares++;
      $display("FAIL hold_level: volume_level=%0d, required 1", volume_level);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/volume_meter.md
VOLUME_METER -- requirements
Module: volume_meter

Interface
REQ-001 Parameter WINDOW_SAMPLES, default 4000: valid microphone samples per measurement window (0.2 s at 20 kHz); legal range 2..65535.
REQ-002 Parameter MID, default 2048: 12-bit ADC code that represents silence (offset-binary zero).
REQ-003 Parameter STEP, default 205: amplitude per volume step; 9*STEP SHALL NOT exceed 2048.
REQ-004 clk  input  1  single system clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 sample_valid  input  1  one-cycle strobe; mic_in is accepted only in cycles where this is high.
REQ-007 mic_in  input  12  unsigned microphone ADC sample.
REQ-008 volume_level  output  4  current volume level, 0..9; consumed by the LED-bar/7-segment display block.
REQ-009 level_valid  output  1  one-cycle pulse in the same cycle that volume_level takes a newly computed value.

Function
REQ-010 Amplitude SHALL be computed as a = mic_in - MID when mic_in >= MID, else MID - mic_in, held in 12 bits (maximum 2048, so no overflow).
REQ-011 The peak register SHALL hold the maximum amplitude over the valid samples of the current window; comparison is unsigned and ties leave the register unchanged.
REQ-012 The window counter SHALL count accepted samples 0..WINDOW_SAMPLES-1 and wrap to 0; cycles without sample_valid change neither the counter nor the peak register.
REQ-013 On the terminal sample (counter = WINDOW_SAMPLES-1 with sample_valid high), window_peak SHALL be max(peak register, amplitude of that sample); the terminal sample counts toward the closing window.
REQ-014 On that same edge, the peak register SHALL clear to 0 and the counter SHALL wrap to 0, so the next window starts empty.
REQ-015 window_level SHALL be the largest k in 0..9 with window_peak >= k*STEP, computed by constant comparators; a divider SHALL NOT be used.
REQ-016 Timing: volume_level and level_valid SHALL update on the clock edge that accepts the terminal sample, giving one cycle of latency from the terminal sample to the registered output.
REQ-017 volume_level SHALL hold its value between updates and SHALL never exceed 9.
REQ-018 level_valid SHALL be high for exactly one cycle per completed window and low at all other times.
REQ-019 Samples with sample_valid high on consecutive cycles SHALL all be accepted; there is no back-pressure.

Reset
REQ-020 While reset is high: volume_level = 0, level_valid = 0, peak register = 0, window counter = 0; any sample presented with sample_valid is discarded.
REQ-021 Reset asserted mid-window SHALL discard the partial window; the first window after reset is a full WINDOW_SAMPLES samples long.
REQ-022 Reset SHALL take priority over a simultaneous terminal sample: no level_valid pulse is produced.

Configuration
REQ-023 Macro VOLUME_METER_DECAY_EN defined: on each update, volume_level <= window_level if window_level >= volume_level, else volume_level - 1 (fall-off of at most one step per window).
REQ-024 Macro VOLUME_METER_DECAY_EN undefined: on each update, volume_level <= window_level directly; no decay logic is present.
REQ-025 With either setting, level_valid timing is identical.

Verification
REQ-026 WINDOW_SAMPLES=8, eight samples mic_in=2048 -> one level_valid pulse, volume_level=0.
REQ-027 Window of 2048 except one sample at 2458 (a=410) -> volume_level=2; a repeat with 2252 (a=204) -> 0; with 2253 (a=205) -> 1.
REQ-028 Window containing mic_in=0 (a=2048) -> volume_level=9, with no wrap or overflow.
REQ-029 Decay build: a window at level 9 followed by three silent windows -> 8, 7, 6 with the macro defined; 9, 0, 0, 0 with it undefined.
REQ-030 Reset asserted after 5 of 8 loud samples, then 8 silent samples -> no pulse before the 8th post-reset sample; then level_valid=1 and volume_level=0.
REQ-031 sample_valid asserted every 3rd cycle -> pulse only after the 8th accepted sample; the peak ignores mic_in in invalid cycles (drive 0 there).
